// File: rtl/elevator_scan_controller.sv
// rtl/elevator_scan_controller.sv - N-floor elevator controller with SCAN sweep policy
module elevator_scan_controller #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  moving,
    output logic                  direction,
    output logic                  door_open,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_DOOR   = 2'd2;

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

    logic [1:0]            state;
    logic [TW-1:0]         travel_cnt;
    logic [DW-1:0]         door_cnt;
    logic [NUM_FLOORS-1:0] eff;
    logic [NUM_FLOORS-1:0] floor_bit;
    logic [NUM_FLOORS-1:0] nf_bit;
    logic [FLOOR_W-1:0]    nf;
    logic                  ahead_up;
    logic                  ahead_dn;
    logic                  beyond_up;
    logic                  beyond_dn;

    // nf only matters in MOVING, where the ahead logic keeps it in range
    always_comb begin
        eff       = pending | call_req;
        nf        = direction ? floor + 1'b1 : floor - 1'b1;
        floor_bit = NUM_FLOORS'(1) << floor;
        nf_bit    = NUM_FLOORS'(1) << nf;
        ahead_up  = 1'b0;
        ahead_dn  = 1'b0;
        beyond_up = 1'b0;
        beyond_dn = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (eff[i] && i > int'(floor)) ahead_up  = 1'b1;
            if (eff[i] && i < int'(floor)) ahead_dn  = 1'b1;
            if (eff[i] && i > int'(nf))    beyond_up = 1'b1;
            if (eff[i] && i < int'(nf))    beyond_dn = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            floor      <= '0;
            direction  <= 1'b1;
            arrived    <= 1'b0;
            pending    <= '0;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else begin
            arrived <= 1'b0;
            pending <= eff;
            case (state)
                ST_IDLE: begin
                    if ((eff & floor_bit) != '0) begin
                        state    <= ST_DOOR;
                        pending  <= eff & ~floor_bit;
                        door_cnt <= DOOR_LOAD;
                    end else if (direction ? ahead_up : ahead_dn) begin
                        state      <= ST_MOVING;
                        travel_cnt <= TRAVEL_LOAD;
                    end else if (direction ? ahead_dn : ahead_up) begin
                        state      <= ST_MOVING;
                        direction  <= ~direction;
                        travel_cnt <= TRAVEL_LOAD;
                    end
                end
                ST_MOVING: begin
                    if (travel_cnt == '0) begin
                        floor   <= nf;
                        arrived <= 1'b1;
                        if ((eff & nf_bit) != '0) begin
                            state    <= ST_DOOR;
                            pending  <= eff & ~nf_bit;
                            door_cnt <= DOOR_LOAD;
                        end else if (direction ? beyond_up : beyond_dn) begin
                            travel_cnt <= TRAVEL_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        travel_cnt <= travel_cnt - 1'b1;
                    end
                end
                ST_DOOR: begin
                    // a call for the open floor just holds the door, never latches
                    pending <= eff & ~floor_bit;
                    if ((call_req & floor_bit) != '0) begin
                        door_cnt <= DOOR_LOAD;
                    end else if (door_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        door_cnt <= door_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign moving    = (state == ST_MOVING);
    assign door_open = (state == ST_DOOR);

    always_ff @(posedge clk) begin
        if (!reset && state == ST_MOVING) begin
            assert (!(int'(floor) == NUM_FLOORS - 1 && direction));
            assert (!(floor == '0 && !direction));
        end
    end

endmodule
